// File: rtl/eip_chain_checker.sv
// Sequential EIP chain checker for the Tiny86 execute path: checks that each retired step follows the previous step's next_eip.
// Define SHADOW_STACK_EN to build the shadow return stack that validates RET targets against matching CALLs.
module eip_chain_checker #(
    parameter int STACK_DEPTH = 16,
    parameter int STACK_AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_valid,
    output logic        step_ready,
    input  logic [31:0] step_eip,
    input  logic [31:0] step_next_eip,
    input  logic [31:0] step_seq_eip,
    input  logic        step_is_call,
    input  logic        step_is_ret,
    input  logic        step_last,
    output logic        done,
    output logic        ok,
    output logic [2:0]  fail_code,
    output logic [31:0] fail_index,
    output logic [31:0] step_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] exp_eip;
    logic        accept;
    logic        chain_bad;
    logic [2:0]  viol_code;

    assign step_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign accept     = step_valid && step_ready;
    assign done       = (state == ST_PASS) || (state == ST_FAIL);
    assign ok         = (state == ST_PASS);

    // The first step after reset is an anchor and is never chain-checked.
    assign chain_bad  = (state == ST_RUN) && (step_eip != exp_eip);

`ifdef SHADOW_STACK_EN
    logic [31:0]         stack_mem [STACK_DEPTH];
    logic [STACK_AW:0]   sp;
    logic [STACK_AW-1:0] top_idx;
    logic [31:0]         top_val;
    logic                stack_empty;
    logic                stack_full;
    logic                push;
    logic                pop;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == STACK_DEPTH[STACK_AW:0]);
    assign top_idx     = sp[STACK_AW-1:0] - STACK_AW'(1);
    assign top_val     = stack_mem[top_idx];

    always_comb begin
        viol_code = 3'd0;
        if (step_is_call && step_is_ret) begin
            viol_code = 3'd1;
        end else if (chain_bad) begin
            viol_code = 3'd2;
        end else if (step_is_ret && stack_empty) begin
            viol_code = 3'd3;
        end else if (step_is_ret && (step_next_eip != top_val)) begin
            viol_code = 3'd4;
        end else if (step_is_call && stack_full) begin
            viol_code = 3'd5;
        end
    end

    // A failing step leaves the stack untouched.
    assign push = accept && (viol_code == 3'd0) && step_is_call;
    assign pop  = accept && (viol_code == 3'd0) && step_is_ret;

    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp[STACK_AW-1:0]] <= step_seq_eip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + (STACK_AW+1)'(1);
        end else if (pop) begin
            sp <= sp - (STACK_AW+1)'(1);
        end
    end
`else
    logic unused_stack_inputs;

    assign unused_stack_inputs = ^{step_is_call, step_is_ret, step_seq_eip,
                                   STACK_DEPTH[0], STACK_AW[0]};

    always_comb begin
        viol_code = 3'd0;
        if (chain_bad) begin
            viol_code = 3'd2;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (viol_code != 3'd0) begin
                        next_state = ST_FAIL;
                    end else if (step_last) begin
                        next_state = ST_PASS;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
            end
            default: next_state = state;
        endcase
    end

    // Only the first violation is recorded; the FSM stops accepting afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_eip    <= 32'd0;
            step_count <= 32'd0;
            fail_code  <= 3'd0;
            fail_index <= 32'd0;
        end else if (accept) begin
            exp_eip <= step_next_eip;
            if (step_count != 32'hFFFF_FFFF) begin
                step_count <= step_count + 32'd1;
            end
            if (viol_code != 3'd0) begin
                fail_code  <= viol_code;
                fail_index <= step_count;
            end
        end
    end

endmodule

// File: doc/eip_chain_checker.md
# eip_chain_checker

Sequential consumer of the control-flow unit's output in the Tiny86 execute path. Accepts one retired step per valid/ready handshake, checks that each step's EIP equals the next EIP computed for the previous step, and latches the first violation with its step index. An optional shadow return stack also checks that every RET lands on the address pushed by the matching CALL.

## Interface
Parameters:
- `STACK_DEPTH`, 16: shadow stack entries; power of two, 2..256.
- `STACK_AW`, 4: stack pointer width; equals log2(`STACK_DEPTH`).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `step_valid`  in  1  step presented.
- `step_ready`  out  1  checker can accept a step.
- `step_eip`  in  32  EIP of the presented step.
- `step_next_eip`  in  32  control-flow unit `next_eip` for this step.
- `step_seq_eip`  in  32  sequential EIP (eip + instr_len), the return address for CALL.
- `step_is_call`  in  1  step is CALLr/CALLi.
- `step_is_ret`  in  1  step is RET.
- `step_last`  in  1  final step of the trace.
- `done`  out  1  checker has reached a terminal state.
- `ok`  out  1  trace completed with no violation.
- `fail_code`  out  3  first violation; 0 means none.
- `fail_index`  out  32  0-based index of the failing step.
- `step_count`  out  32  accepted steps; saturates at 32'hFFFF_FFFF.

## Operation
- States: IDLE, RUN, PASS, FAIL. A step is accepted when `step_valid & step_ready`.
- `step_ready` = 1 in IDLE and RUN, 0 in PASS and FAIL. It is decoded combinationally from the state register only, never from `step_valid`.
- IDLE, accepted step: `step_eip` is taken as the anchor with no chain check. Load `exp_eip` <= `step_next_eip`. Go to RUN, or to PASS if `step_last` is set (FAIL if a violation was found).
- RUN, accepted step: chain check `step_eip == exp_eip`. Load `exp_eip` <= `step_next_eip`. If `step_last` is set, go to PASS when there is no violation.
- Violation on any accepted step: go to FAIL. Latch `fail_code` and set `fail_index` = `step_count` before increment.
- When one step has several violations, the lowest code wins:
  - 1: `step_is_call & step_is_ret` (malformed).
  - 2: chain mismatch.
  - 3: RET with stack empty.
  - 4: RET target mismatch (`step_next_eip` != top of stack).
  - 5: CALL with stack full.
- Stack actions on a step with no violation:
  - CALL pushes `step_seq_eip`.
  - RET pops.
  - A failing step causes no push and no pop.
- `step_count` increments on every accepted step, including the failing step and the last step.
- PASS and FAIL hold until reset. `done` = state is PASS or FAIL. `ok` = state is PASS.
- Reset mid-trace discards all state. The next accepted step is a new anchor.

## Timing
- Reset values:
  - state IDLE; `step_ready` 1.
  - `done` 0, `ok` 0, `fail_code` 0, `fail_index` 0, `step_count` 0.
  - `exp_eip` 0, stack pointer 0.
- Throughput is one step per cycle; there are no bubbles in IDLE or RUN.
- Latency is 1 cycle: `done`, `ok`, `fail_code`, `fail_index` and `step_count` are registered and reflect a step on the cycle after its acceptance.
- `step_ready` drops the cycle after the terminal step is accepted. A step presented in that cycle is not accepted.
- Inputs other than `step_valid` are don't-care when no step is accepted.

## Configuration
- `SHADOW_STACK_EN` defined:
  - Stack storage of `STACK_DEPTH` x 32 and the stack pointer are built.
  - Codes 3, 4 and 5 are produced as described above.
- `SHADOW_STACK_EN` undefined:
  - No stack storage is built.
  - `step_is_call`, `step_is_ret` and `step_seq_eip` are ignored, and codes 1, 3, 4 and 5 are never produced.
  - The `STACK_DEPTH` and `STACK_AW` parameters remain declared but unused.

## Test plan
- Chain pass: steps (eip, next) = (0x100,0x102), (0x102,0x110), (0x110,0x112 last) -> PASS; `ok`=1, `fail_code`=0, `step_count`=3.
- Chain break: second step has eip 0x104 where 0x102 is expected -> FAIL; `fail_code`=2, `fail_index`=1, `step_ready`=0 the next cycle, and further valid steps are not counted.
- Call/return (stack on):
  - CALL at 0x100 with seq 0x105 and next 0x200.
  - Step at 0x200 with next 0x201.
  - RET at 0x201 with next 0x105.
  - Step at 0x105, last.
  - Required: PASS. The same sequence with RET next 0x106 -> `fail_code`=4, `fail_index`=2.
- Stack limits (`STACK_DEPTH`=2):
  - Three chained CALLs -> `fail_code`=5, `fail_index`=2.
  - A RET as the first step -> `fail_code`=3, `fail_index`=0.
- Priority: a step with both CALL and RET set and a chain mismatch -> `fail_code`=1.
- Reset: deassert `rst_n` asynchronously after 5 accepted steps -> all outputs return to their reset values immediately. The next step is an anchor; a mismatch against the old `exp_eip` is not flagged.
